// File: rtl/multi_digit_bcd_counter_pkg.sv
// Shared constants and helpers for the multi-digit BCD counter.
// Latency: none (constants and pure functions only).
// Backpressure: not applicable.
package bcd_counter_pkg;

    localparam logic [3:0] BCD_MAX = 4'd9;

    // Segment order is {g,f,e,d,c,b,a}, active-high
    localparam logic [6:0] SEG_0     = 7'b0111111;
    localparam logic [6:0] SEG_1     = 7'b0000110;
    localparam logic [6:0] SEG_2     = 7'b1011011;
    localparam logic [6:0] SEG_3     = 7'b1001111;
    localparam logic [6:0] SEG_4     = 7'b1100110;
    localparam logic [6:0] SEG_5     = 7'b1101101;
    localparam logic [6:0] SEG_6     = 7'b1111101;
    localparam logic [6:0] SEG_7     = 7'b0000111;
    localparam logic [6:0] SEG_8     = 7'b1111111;
    localparam logic [6:0] SEG_9     = 7'b1101111;
    localparam logic [6:0] SEG_BLANK = 7'b0000000;

    // Digit to segment pattern; codes above 9 cannot reach the register but decode dark
    function automatic logic [6:0] seg7(input logic [3:0] d);
        logic [6:0] s;
        case (d)
            4'd0:    s = SEG_0;
            4'd1:    s = SEG_1;
            4'd2:    s = SEG_2;
            4'd3:    s = SEG_3;
            4'd4:    s = SEG_4;
            4'd5:    s = SEG_5;
            4'd6:    s = SEG_6;
            4'd7:    s = SEG_7;
            4'd8:    s = SEG_8;
            4'd9:    s = SEG_9;
            default: s = SEG_BLANK;
        endcase
        return s;
    endfunction

    // Out-of-range load nibbles saturate to 9 so the count is always valid BCD
    function automatic logic [3:0] bcd_clamp(input logic [3:0] n);
        return (n > BCD_MAX) ? BCD_MAX : n;
    endfunction

endpackage

// File: rtl/multi_digit_bcd_counter_digit_cell.sv
// One BCD digit register with increment/decrement and combinational carry/borrow out.
// Latency: digit updates on the clock edge after inc/dec/load; carry/borrow are same-cycle.
// Backpressure: none; inc/dec are single-cycle strobes from the lower digit or the top.
module bcd_digit_cell
    import bcd_counter_pkg::*;
(
    input  logic       clock,
    input  logic       reset,
    input  logic       inc,
    input  logic       dec,
    input  logic       load,
    input  logic [3:0] load_nibble,
    output logic [3:0] digit,
    output logic       carry_out,
    output logic       borrow_out
);

    logic [3:0] digit_d;
    logic [3:0] digit_q;

    // Next digit: load beats inc/dec; inc and dec are never both set by the top
    always_comb begin
        digit_d = digit_q;
        if (load) begin
            digit_d = bcd_clamp(load_nibble);
        end else if (inc) begin
            digit_d = (digit_q == BCD_MAX) ? 4'd0 : digit_q + 4'd1;
        end else if (dec) begin
            digit_d = (digit_q == 4'd0) ? BCD_MAX : digit_q - 4'd1;
        end
    end

    // Digit register with synchronous reset
    always_ff @(posedge clock) begin
        if (reset) begin
            digit_q <= 4'd0;
        end else begin
            digit_q <= digit_d;
        end
    end

    assign digit      = digit_q;
    assign carry_out  = inc & (digit_q == BCD_MAX);
    assign borrow_out = dec & (digit_q == 4'd0);

endmodule

// File: rtl/multi_digit_bcd_counter.sv
// N-digit BCD up/down counter with tick prescaler, load and 7-segment outputs.
// Latency: bcd/step/wrap one edge after the due tick; digits one further cycle.
// Backpressure: none; enable holds the prescaler. Option: LEADING_ZERO_BLANK_EN.
module multi_digit_bcd_counter
    import bcd_counter_pkg::*;
#(
    parameter int NUM_DIGITS = 4,
    parameter int TICK_DIV   = 50_000_000
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    enable,
    input  logic                    up_down,
    input  logic                    load,
    input  logic [4*NUM_DIGITS-1:0] load_value,
    output logic [4*NUM_DIGITS-1:0] bcd,
    output logic [7*NUM_DIGITS-1:0] digits,
    output logic                    step,
    output logic                    wrap
);

    // A TICK_DIV of 1 still gets a 1-bit prescaler that simply sits at 0
    localparam int            PW         = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);

    logic [PW-1:0]           presc_d, presc_q;
    logic                    step_d, step_q;
    logic                    wrap_d, wrap_q;
    logic [7*NUM_DIGITS-1:0] seg_d, seg_q;

    logic                    step_due;
    logic                    step_apply;
    logic                    step_up;
    logic                    step_dn;
    logic [4*NUM_DIGITS-1:0] bcd_w;
    logic                    top_carry;
    logic                    top_borrow;

    // A load in the due cycle swallows that step
    assign step_due   = enable & (presc_q == PRESC_LAST);
    assign step_apply = step_due & ~load;
    assign step_up    = step_apply & up_down;
    assign step_dn    = step_apply & ~up_down;

    // Digit chain: each cell's carry/borrow feeds the next higher digit in the same cycle
    for (genvar i = 0; i < NUM_DIGITS; i++) begin : g_digit
        logic       inc_w;
        logic       dec_w;
        logic       carry_w;
        logic       borrow_w;
        logic [3:0] digit_w;

        if (i == 0) begin : g_lsb
            assign inc_w = step_up;
            assign dec_w = step_dn;
        end else begin : g_upper
            assign inc_w = g_digit[i-1].carry_w;
            assign dec_w = g_digit[i-1].borrow_w;
        end

        bcd_digit_cell u_cell (
            .clock       (clock),
            .reset       (reset),
            .inc         (inc_w),
            .dec         (dec_w),
            .load        (load),
            .load_nibble (load_value[4*i +: 4]),
            .digit       (digit_w),
            .carry_out   (carry_w),
            .borrow_out  (borrow_w)
        );

        assign bcd_w[4*i +: 4] = digit_w;
    end

    // A carry or borrow leaving the top digit means the whole count wrapped
    assign top_carry  = g_digit[NUM_DIGITS-1].carry_w;
    assign top_borrow = g_digit[NUM_DIGITS-1].borrow_w;

    // Prescaler and step/wrap next state; load clears the prescaler and suppresses pulses
    always_comb begin
        presc_d = presc_q;
        if (load) begin
            presc_d = '0;
        end else if (enable) begin
            presc_d = step_due ? '0 : presc_q + PW'(1);
        end
        step_d = step_apply;
        wrap_d = step_apply & (top_carry | top_borrow);
    end

`ifdef LEADING_ZERO_BLANK_EN
    logic lead_zero;

    // Segment decode, darkening every digit above the most significant nonzero one
    always_comb begin
        seg_d     = '0;
        lead_zero = 1'b1;
        for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
            if (i == 0 || bcd_w[4*i +: 4] != 4'd0) begin
                lead_zero = 1'b0;
            end
            seg_d[7*i +: 7] = lead_zero ? SEG_BLANK : seg7(bcd_w[4*i +: 4]);
        end
    end
`else
    // Segment decode of every digit, leading zeros included
    always_comb begin
        seg_d = '0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            seg_d[7*i +: 7] = seg7(bcd_w[4*i +: 4]);
        end
    end
`endif

    // Top-level registers; reset shows "0" on every digit regardless of blanking
    always_ff @(posedge clock) begin
        if (reset) begin
            presc_q <= '0;
            step_q  <= 1'b0;
            wrap_q  <= 1'b0;
            seg_q   <= {NUM_DIGITS{SEG_0}};
        end else begin
            presc_q <= presc_d;
            step_q  <= step_d;
            wrap_q  <= wrap_d;
            seg_q   <= seg_d;
        end
    end

    assign bcd    = bcd_w;
    assign digits = seg_q;
    assign step   = step_q;
    assign wrap   = wrap_q;

endmodule

// File: tb/tb_multi_digit_bcd_counter.sv
// Bench for multi_digit_bcd_counter: directed table, corner sequences and a random run
// checked every cycle against an integer-arithmetic reference model.
// Honours LEADING_ZERO_BLANK_EN when expecting segment patterns.
module tb_multi_digit_bcd_counter;

    localparam int ND  = 4;
    localparam int TD  = 3;
    localparam int MOD = 10000;
`ifdef LEADING_ZERO_BLANK_EN
    localparam bit BLANK = 1'b1;
`else
    localparam bit BLANK = 1'b0;
`endif
    localparam logic [6:0]  SEGTAB [10] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
                                           7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};
    localparam logic [27:0] ALL0 = {4{7'h3F}};

    logic        clock = 1'b0;
    logic        reset, enable, up_down, load;
    logic [15:0] load_value, bcd;
    logic [27:0] digits;
    logic        step, wrap;

    logic        r1, en1, ud1, ld1;
    logic [15:0] lv1, bcd1;
    logic [27:0] dig1;
    logic        step1, wrap1;

    int n_vec = 0;
    int n_bad = 0;

    always #5 clock = ~clock;

    multi_digit_bcd_counter #(.NUM_DIGITS(ND), .TICK_DIV(TD)) dut (
        .clock(clock), .reset(reset), .enable(enable), .up_down(up_down),
        .load(load), .load_value(load_value), .bcd(bcd), .digits(digits),
        .step(step), .wrap(wrap)
    );

    multi_digit_bcd_counter #(.NUM_DIGITS(ND), .TICK_DIV(1)) dut1 (
        .clock(clock), .reset(r1), .enable(en1), .up_down(ud1),
        .load(ld1), .load_value(lv1), .bcd(bcd1), .digits(dig1),
        .step(step1), .wrap(wrap1)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference helpers: plain decimal arithmetic on the count
    function automatic int bcd2int(input logic [15:0] v);
        int r  = 0;
        int pw = 1;
        for (int i = 0; i < ND; i++) begin
            int n = int'(v[4*i +: 4]);
            r  += ((n > 9) ? 9 : n) * pw;
            pw *= 10;
        end
        return r;
    endfunction

    function automatic logic [15:0] int2bcd(input int v);
        logic [15:0] r = '0;
        int pw = 1;
        for (int i = 0; i < ND; i++) begin
            r[4*i +: 4] = 4'((v / pw) % 10);
            pw *= 10;
        end
        return r;
    endfunction

    function automatic logic [27:0] segs(input int v);
        logic [27:0] r = '0;
        int pw = 1;
        for (int i = 0; i < ND; i++) begin
            if (BLANK && i > 0 && v < pw) r[7*i +: 7] = 7'h00;
            else                          r[7*i +: 7] = SEGTAB[(v / pw) % 10];
            pw *= 10;
        end
        return r;
    endfunction

    // Reference model of the TICK_DIV=3 instance, advanced on each rising edge
    int          m_cnt = 0, m_presc = 0;
    logic        m_step = 1'b0, m_wrap = 1'b0, m_valid = 1'b0;
    logic [27:0] m_seg = '0;

    always @(posedge clock) begin
        if (reset) begin
            m_cnt = 0; m_presc = 0; m_step = 1'b0; m_wrap = 1'b0;
            m_seg = ALL0; m_valid = 1'b1;
        end else begin
            m_seg  = segs(m_cnt);
            m_step = 1'b0;
            m_wrap = 1'b0;
            if (load) begin
                m_cnt   = bcd2int(load_value);
                m_presc = 0;
            end else if (enable) begin
                if (m_presc == TD - 1) begin
                    m_presc = 0;
                    m_step  = 1'b1;
                    if (up_down) begin
                        m_wrap = (m_cnt == MOD - 1);
                        m_cnt  = (m_cnt + 1) % MOD;
                    end else begin
                        m_wrap = (m_cnt == 0);
                        m_cnt  = (m_cnt + MOD - 1) % MOD;
                    end
                end else begin
                    m_presc++;
                end
            end
        end
    end

    // Cycle-by-cycle scoreboard on the falling edge
    always @(negedge clock) begin
        if (m_valid) begin
            chk("sb_bcd",    32'(bcd),    32'(int2bcd(m_cnt)));
            chk("sb_digits", 32'(digits), 32'(m_seg));
            chk("sb_step",   32'(step),   32'(m_step));
            chk("sb_wrap",   32'(wrap),   32'(m_wrap));
        end
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    typedef struct {
        logic [15:0] lv;
        logic        ud;
        int          k;
        logic [15:0] exp_bcd;
        logic        exp_wrap;
    } vec_t;

    vec_t tbl [10];

    initial begin
        logic wseen;

        tbl[0] = '{16'h9998, 1'b1, 3, 16'h9999, 1'b0};
        tbl[1] = '{16'h9998, 1'b1, 6, 16'h0000, 1'b1};
        tbl[2] = '{16'h0001, 1'b0, 3, 16'h0000, 1'b0};
        tbl[3] = '{16'h0001, 1'b0, 6, 16'h9999, 1'b1};
        tbl[4] = '{16'h0109, 1'b0, 3, 16'h0108, 1'b0};
        tbl[5] = '{16'hFA35, 1'b1, 0, 16'h9935, 1'b0};
        tbl[6] = '{16'h1239, 1'b1, 3, 16'h1240, 1'b0};
        tbl[7] = '{16'h0990, 1'b0, 3, 16'h0989, 1'b0};
        tbl[8] = '{16'h5000, 1'b0, 9, 16'h4997, 1'b0};
        tbl[9] = '{16'h0099, 1'b1, 2, 16'h0099, 1'b0};

        reset = 1'b1; enable = 1'b0; up_down = 1'b1; load = 1'b0; load_value = '0;
        r1 = 1'b1; en1 = 1'b0; ud1 = 1'b1; ld1 = 1'b0; lv1 = '0;
        repeat (5) tick();
        chk("rst_bcd", 32'(bcd), 32'h0);
        chk("rst_step", 32'(step), 32'h0);
        chk("rst_wrap", 32'(wrap), 32'h0);
        chk("rst_digits", 32'(digits), 32'(ALL0));

        // Count up from reset: one step every 3 clocks, digits one cycle later
        reset = 1'b0; r1 = 1'b0; enable = 1'b1; up_down = 1'b1;
        tick(); tick();
        chk("up_pre_bcd", 32'(bcd), 32'h0);
        tick();
        chk("up1_bcd", 32'(bcd), 32'h0001);
        chk("up1_step", 32'(step), 32'h1);
        tick();
        chk("up1_step_drop", 32'(step), 32'h0);
        chk("up1_dig0", 32'(digits[6:0]), 32'h06);
        tick(); tick();
        chk("up2_bcd", 32'(bcd), 32'h0002);

        // Directed table: load, then k enabled clocks
        for (int t = 0; t < 10; t++) begin
            load = 1'b1; load_value = tbl[t].lv; up_down = tbl[t].ud; enable = 1'b1;
            tick();
            load = 1'b0; wseen = 1'b0;
            repeat (tbl[t].k) begin
                tick();
                wseen |= wrap;
            end
            chk($sformatf("tbl%0d_bcd", t), 32'(bcd), 32'(tbl[t].exp_bcd));
            chk($sformatf("tbl%0d_wrap", t), 32'(wseen), 32'(tbl[t].exp_wrap));
        end

        // Wrap to zero, then check the display of 0000
        load = 1'b1; load_value = 16'h9999; up_down = 1'b1;
        tick();
        load = 1'b0;
        repeat (3) tick();
        chk("wrap_up", 32'(wrap), 32'h1);
        tick();
        chk("wrap_up_once", 32'(wrap), 32'h0);
        chk("zero_digits", 32'(digits), 32'(BLANK ? {21'h0, 7'h3F} : ALL0));

        // Load in the cycle a step is due
        load = 1'b1; load_value = 16'h0500;
        tick();
        load = 1'b0;
        tick(); tick();
        load = 1'b1; load_value = 16'h0700;
        tick();
        load = 1'b0;
        chk("ldstep_bcd", 32'(bcd), 32'h0700);
        chk("ldstep_step", 32'(step), 32'h0);
        tick(); tick();
        chk("ldstep_hold", 32'(bcd), 32'h0700);
        tick();
        chk("ldstep_next", 32'(bcd), 32'h0701);
        chk("ldstep_nstep", 32'(step), 32'h1);

        // Enable low mid-count for 10 cycles
        load = 1'b1; load_value = 16'h0100;
        tick();
        load = 1'b0;
        repeat (4) tick();
        enable = 1'b0;
        repeat (10) tick();
        chk("hold_bcd", 32'(bcd), 32'h0101);
        enable = 1'b1;
        tick();
        chk("resume_wait", 32'(bcd), 32'h0101);
        tick();
        chk("resume_bcd", 32'(bcd), 32'h0102);
        chk("resume_step", 32'(step), 32'h1);

        // Enable drops exactly when a step is due
        load = 1'b1; load_value = 16'h0200;
        tick();
        load = 1'b0;
        tick(); tick();
        enable = 1'b0;
        repeat (5) tick();
        chk("drop_hold", 32'(bcd), 32'h0200);
        enable = 1'b1;
        tick();
        chk("drop_resume", 32'(bcd), 32'h0201);

        // Reset during a step cycle at 1239
        load = 1'b1; load_value = 16'h1239;
        tick();
        load = 1'b0;
        tick(); tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("rststep_bcd", 32'(bcd), 32'h0);
        chk("rststep_wrap", 32'(wrap), 32'h0);
        chk("rststep_step", 32'(step), 32'h0);
        chk("rststep_dig", 32'(digits), 32'(ALL0));

        // Same with a step every cycle
        ld1 = 1'b1; lv1 = 16'h1239; en1 = 1'b1; ud1 = 1'b1;
        tick();
        chk("d1_load", 32'(bcd1), 32'h1239);
        ld1 = 1'b0; r1 = 1'b1;
        tick();
        r1 = 1'b0;
        chk("d1_rst_bcd", 32'(bcd1), 32'h0);
        chk("d1_rst_step", 32'(step1), 32'h0);
        chk("d1_rst_wrap", 32'(wrap1), 32'h0);
        chk("d1_rst_dig", 32'(dig1), 32'(ALL0));
        tick();
        chk("d1_step1", 32'(bcd1), 32'h0001);
        chk("d1_step1_p", 32'(step1), 32'h1);
        tick();
        chk("d1_step2", 32'(bcd1), 32'h0002);
        ld1 = 1'b1; lv1 = 16'h9999;
        tick();
        ld1 = 1'b0;
        tick();
        chk("d1_wrap_bcd", 32'(bcd1), 32'h0);
        chk("d1_wrap", 32'(wrap1), 32'h1);
        en1 = 1'b0;

        // Random run checked by the scoreboard
        for (int c = 0; c < 2000; c++) begin
            reset   = ($urandom_range(0, 199) == 0);
            load    = ($urandom_range(0, 24) == 0);
            enable  = ($urandom_range(0, 9) != 0);
            up_down = ($urandom_range(0, 3) != 0) ? up_down : ~up_down;
            case ($urandom_range(0, 3))
                0:       load_value = 16'h9997;
                1:       load_value = 16'h0002;
                default: load_value = 16'($urandom);
            endcase
            tick();
        end
        reset = 1'b0; load = 1'b0;
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
